// File: rtl/rv_core_pkg.sv
// Shared types and constants for the multicycle RISC-V core front end.
package rv_core_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_ISSUE,
    FS_CAPTURE,
    FS_HOLD,
    FS_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } instr_reg_t;
endpackage

// File: rtl/fetch_pc_check.sv
// Combinational fetch address legality: word aligned and inside instruction memory.
module fetch_pc_check
  import rv_core_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic [XLEN-1:0] addr,
  output logic            legal
);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(MEM_WORDS);

  always_comb legal = (addr[1:0] == 2'b00) && ({2'b00, addr[XLEN-1:2]} < LIMIT);
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the instruction memory read port and
// hands fetched words to the control FSM over a valid/ready handshake.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);
  localparam int NCHK    = 3;
  localparam int CHK_PC  = 0;
  localparam int CHK_INC = 1;
  localparam int CHK_RDR = 2;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc;
  instr_reg_t      ir_q, ir_d;
  logic            fault_q, fault_d;

  logic [NCHK-1:0][XLEN-1:0] chk_addr;
  logic [NCHK-1:0]           chk_legal;

  assign pc_inc = pc_q + XLEN'(INSTR_BYTES);

  always_comb begin
    chk_addr          = '0;
    chk_addr[CHK_PC]  = pc_q;
    chk_addr[CHK_INC] = pc_inc;
    chk_addr[CHK_RDR] = redirect_pc;
  end

  for (genvar i = 0; i < NCHK; i++) begin : g_chk
    fetch_pc_check #(.MEM_WORDS(MEM_WORDS)) u_chk (
      .addr  (chk_addr[i]),
      .legal (chk_legal[i])
    );
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    // A redirect overrides whatever is in flight; the pending read is dropped.
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      ir_d.vld = 1'b0;
      if (!chk_legal[CHK_RDR]) begin
        state_d = FS_FAULT;
        fault_d = 1'b1;
      end else begin
        state_d = fetch_en ? FS_ISSUE : FS_IDLE;
        fault_d = 1'b0;
      end
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (fetch_en) begin
            if (chk_legal[CHK_PC]) begin
              state_d = FS_ISSUE;
            end else begin
              state_d = FS_FAULT;
              fault_d = 1'b1;
            end
          end
        end
        FS_ISSUE: state_d = FS_CAPTURE;
        FS_CAPTURE: begin
          ir_d.data = mem_rdata;
          ir_d.pc   = pc_q;
          ir_d.vld  = 1'b1;
          state_d   = FS_HOLD;
        end
        FS_HOLD: begin
          if (instr_ready) begin
            ir_d.vld = 1'b0;
            pc_d     = pc_inc;
            if (!chk_legal[CHK_INC]) begin
              state_d = FS_FAULT;
              fault_d = 1'b1;
            end else begin
              state_d = fetch_en ? FS_ISSUE : FS_IDLE;
            end
          end
        end
        FS_FAULT: state_d = FS_FAULT;
        default: begin
          state_d  = FS_IDLE;
          ir_d.vld = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  assign mem_sel     = (state_q != FS_ISSUE);
  assign mem_addr    = pc_q;
  assign instr_valid = ir_q.vld;
  assign instr       = ir_q.data;
  assign instr_pc    = ir_q.pc;
  assign fetch_fault = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle-by-cycle vectors for instr_fetch_unit plus stream latency checks.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, fetch_en, mem_sel, instr_valid, instr_ready;
  logic        redirect_valid, fetch_fault;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;

  logic [31:0] mem [0:31];
  int          n_pass = 0, n_total = 0, bad_issue = 0;

  typedef struct {
    logic        rst_n, en, rdy, rv;
    logic [31:0] rpc;
    logic        sel;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins, ipc;
    logic        ff;
  } vec_t;
  vec_t vecs[$];

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00a0_0113;
  localparam logic [31:0] W2 = 32'h0020_81b3;

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .mem_sel        (mem_sel),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory; out-of-range reads return a marker.
  always @(posedge clk) begin
    if (!mem_sel) begin
      mem_rdata <= (mem_addr < 32'd128) ? mem[mem_addr[6:2]] : 32'hDEAD_BEEF;
      if (rst_n && (mem_addr[1:0] != 2'b00 || mem_addr >= 32'd128)) bad_issue <= bad_issue + 1;
    end
  end

  function automatic void add(input logic r, input logic e, input logic y, input logic v,
                              input logic [31:0] rp, input logic s, input logic [31:0] a,
                              input logic vl, input logic [31:0] in, input logic [31:0] ip,
                              input logic f);
    vec_t t;
    t.rst_n = r; t.en = e; t.rdy = y; t.rv = v; t.rpc = rp;
    t.sel = s; t.addr = a; t.vld = vl; t.ins = in; t.ipc = ip; t.ff = f;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    int k, j;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = W0; mem[1] = W1; mem[2] = W2;
    mem_rdata = '0;
    rst_n = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;

    //   rst en rdy rv rpc        sel addr      vld instr          ipc       ff
    add(0, 1, 1, 0, 32'h0,      1, 32'h0,  0, 32'h0,         32'h0,  0); // reset
    add(1, 1, 1, 0, 32'h0,      0, 32'h0,  0, 32'h0,         32'h0,  0); // ISSUE 0
    add(1, 1, 1, 0, 32'h0,      1, 32'h0,  0, 32'h0,         32'h0,  0);
    add(1, 1, 1, 0, 32'h0,      1, 32'h0,  1, W0,            32'h0,  0);
    add(1, 1, 1, 0, 32'h0,      0, 32'h4,  0, W0,            32'h0,  0);
    add(1, 1, 1, 0, 32'h0,      1, 32'h4,  0, W0,            32'h0,  0);
    add(1, 1, 1, 0, 32'h0,      1, 32'h4,  1, W1,            32'h4,  0);
    add(1, 1, 1, 0, 32'h0,      0, 32'h8,  0, W1,            32'h4,  0);
    add(1, 1, 1, 0, 32'h0,      1, 32'h8,  0, W1,            32'h4,  0);
    add(1, 1, 1, 0, 32'h0,      1, 32'h8,  1, W2,            32'h8,  0);
    for (int i = 0; i < 5; i++)                                           // stall
      add(1, 1, 0, 0, 32'h0,    1, 32'h8,  1, W2,            32'h8,  0);
    add(1, 1, 1, 0, 32'h0,      0, 32'hC,  0, W2,            32'h8,  0);
    add(1, 1, 1, 0, 32'h0,      1, 32'hC,  0, W2,            32'h8,  0);
    add(1, 1, 0, 0, 32'h0,      1, 32'hC,  1, 32'hA0000003,  32'hC,  0);
    add(1, 1, 0, 1, 32'h4,      0, 32'h4,  0, 32'hA0000003,  32'hC,  0); // redirect in HOLD
    add(1, 1, 0, 0, 32'h0,      1, 32'h4,  0, 32'hA0000003,  32'hC,  0);
    add(1, 1, 0, 1, 32'h10,     0, 32'h10, 0, 32'hA0000003,  32'hC,  0); // redirect in CAPTURE
    add(1, 1, 0, 0, 32'h0,      1, 32'h10, 0, 32'hA0000003,  32'hC,  0);
    add(1, 1, 0, 0, 32'h0,      1, 32'h10, 1, 32'hA0000004,  32'h10, 0);
    add(1, 1, 1, 1, 32'h20,     0, 32'h20, 0, 32'hA0000004,  32'h10, 0); // redirect beats ready
    add(1, 1, 0, 0, 32'h0,      1, 32'h20, 0, 32'hA0000004,  32'h10, 0);
    add(1, 1, 0, 0, 32'h0,      1, 32'h20, 1, 32'hA0000008,  32'h20, 0);
    add(1, 1, 0, 1, 32'h6,      1, 32'h6,  0, 32'hA0000008,  32'h20, 1); // misaligned
    add(1, 1, 1, 0, 32'h0,      1, 32'h6,  0, 32'hA0000008,  32'h20, 1);
    add(1, 1, 1, 0, 32'h0,      1, 32'h6,  0, 32'hA0000008,  32'h20, 1);
    add(1, 1, 0, 1, 32'h8,      0, 32'h8,  0, 32'hA0000008,  32'h20, 0); // recover
    add(1, 1, 0, 0, 32'h0,      1, 32'h8,  0, 32'hA0000008,  32'h20, 0);
    add(1, 1, 0, 0, 32'h0,      1, 32'h8,  1, W2,            32'h8,  0);
    add(1, 1, 0, 1, 32'h7C,     0, 32'h7C, 0, W2,            32'h8,  0); // last word
    add(1, 1, 0, 0, 32'h0,      1, 32'h7C, 0, W2,            32'h8,  0);
    add(1, 1, 0, 0, 32'h0,      1, 32'h7C, 1, 32'hA000001F,  32'h7C, 0);
    add(1, 1, 1, 0, 32'h0,      1, 32'h80, 0, 32'hA000001F,  32'h7C, 1); // off the end
    add(1, 1, 1, 0, 32'h0,      1, 32'h80, 0, 32'hA000001F,  32'h7C, 1);
    add(1, 0, 0, 1, 32'h0,      1, 32'h0,  0, 32'hA000001F,  32'h7C, 0); // legal redirect, en=0
    add(1, 1, 0, 0, 32'h0,      0, 32'h0,  0, 32'hA000001F,  32'h7C, 0);
    add(1, 0, 0, 0, 32'h0,      1, 32'h0,  0, 32'hA000001F,  32'h7C, 0); // en drop mid-fetch
    add(1, 0, 0, 0, 32'h0,      1, 32'h0,  1, W0,            32'h0,  0);
    add(1, 0, 1, 0, 32'h0,      1, 32'h4,  0, W0,            32'h0,  0);
    add(1, 0, 1, 0, 32'h0,      1, 32'h4,  0, W0,            32'h0,  0);
    add(1, 1, 0, 0, 32'h0,      0, 32'h4,  0, W0,            32'h0,  0);
    add(0, 1, 0, 0, 32'h0,      1, 32'h0,  0, 32'h0,         32'h0,  0); // reset in ISSUE
    add(1, 0, 0, 0, 32'h0,      1, 32'h0,  0, 32'h0,         32'h0,  0);
    add(1, 1, 0, 0, 32'h0,      0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(1, 1, 0, 0, 32'h0,      1, 32'h0,  0, 32'h0,         32'h0,  0);
    add(1, 1, 0, 0, 32'h0,      1, 32'h0,  1, W0,            32'h0,  0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; fetch_en = vecs[i].en; instr_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      @(posedge clk); #1;
      n_total++;
      if ({mem_sel, mem_addr, instr_valid, instr, instr_pc, fetch_fault} ===
          {vecs[i].sel, vecs[i].addr, vecs[i].vld, vecs[i].ins, vecs[i].ipc, vecs[i].ff})
        n_pass++;
      else
        $display("FAIL vec%0d: got sel=%b addr=%h vld=%b instr=%h ipc=%h ff=%b expected sel=%b addr=%h vld=%b instr=%h ipc=%h ff=%b",
                 i, mem_sel, mem_addr, instr_valid, instr, instr_pc, fetch_fault,
                 vecs[i].sel, vecs[i].addr, vecs[i].vld, vecs[i].ins, vecs[i].ipc, vecs[i].ff);
    end

    // Stream timing: first valid 3 edges after reset release, then one per 3 cycles.
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    k = 21;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (instr_valid) begin k = c; break; end
    end
    chk("first_valid_edges", 32'(k), 32'd3);
    chk("first_instr_pc", instr_pc, 32'h0);
    j = 21;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (instr_valid) begin j = c; break; end
    end
    chk("stream_gap", 32'(j), 32'd3);
    chk("second_instr", instr, W1);
    chk("second_instr_pc", instr_pc, 32'h4);
    chk("no_illegal_issue", 32'(bad_issue), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
